// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory slave and the core's control block:
// load/store funct3 encodings, responder FSM states and the default array base.
package mem_pkg;

    // RV32 load funct3 encodings
    typedef enum logic [2:0] {
        LB  = 3'd0,
        LH  = 3'd1,
        LW  = 3'd2,
        LBU = 3'd4,
        LHU = 3'd5
    } load_funct3_e;

    // RV32 store funct3 encodings
    typedef enum logic [2:0] {
        SB = 3'd0,
        SH = 3'd1,
        SW = 3'd2
    } store_funct3_e;

    // Responder sequencing states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0100_0000;

endpackage

// File: rtl/mem_lane_unit.sv
// Byte-lane steering for one 32-bit memory word: store byte enables and merge,
// load extraction with sign/zero extension, plus alignment and funct3 checks.
module mem_lane_unit
    import mem_pkg::*;
(
    input  logic [1:0]  offset_i,
    input  logic [2:0]  funct3_i,
    input  logic        we_i,
    input  logic [31:0] word_i,
    input  logic [31:0] wdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] merged_o,
    output logic [31:0] load_o,
    output logic        misalign_o,
    output logic        illegal_o
);

    logic [31:0] shifted;
    logic [31:0] wdata_rep;

    // Decode the access size, pick the lanes and extract/extend the load value
    always_comb begin
        be_o       = 4'b0000;
        misalign_o = 1'b0;
        illegal_o  = 1'b0;
        load_o     = '0;
        wdata_rep  = wdata_i;
        shifted    = word_i >> {offset_i, 3'b000};
        if (we_i) begin
            case (funct3_i)
                SB: begin
                    be_o      = 4'b0001 << offset_i;
                    wdata_rep = {4{wdata_i[7:0]}};
                end
                SH: begin
                    be_o       = 4'b0011 << offset_i;
                    wdata_rep  = {2{wdata_i[15:0]}};
                    misalign_o = offset_i[0];
                end
                SW: begin
                    be_o       = 4'b1111;
                    misalign_o = (offset_i != 2'b00);
                end
                default: illegal_o = 1'b1;
            endcase
        end else begin
            case (funct3_i)
                LB:  load_o = {{24{shifted[7]}}, shifted[7:0]};
                LH: begin
                    load_o     = {{16{shifted[15]}}, shifted[15:0]};
                    misalign_o = offset_i[0];
                end
                LW: begin
                    load_o     = shifted;
                    misalign_o = (offset_i != 2'b00);
                end
                LBU: load_o = {24'h0, shifted[7:0]};
                LHU: begin
                    load_o     = {16'h0, shifted[15:0]};
                    misalign_o = offset_i[0];
                end
                default: illegal_o = 1'b1;
            endcase
        end
        if (misalign_o || illegal_o) begin
            be_o = 4'b0000;
        end
    end

    // Overlay the enabled store lanes onto the existing word
    always_comb begin
        merged_o = word_i;
        for (int i = 0; i < 4; i++) begin
            if (be_o[i]) begin
                merged_o[8*i +: 8] = wdata_rep[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory slave for the RV32 load/store port: one request at a time,
// serviced after a fixed latency against a word-organised byte-addressed array.
`ifndef MEM_DEPTH
`define MEM_DEPTH 1024
`endif

module dmem_responder
    import mem_pkg::*;
#(
    parameter int                 AWIDTH    = 32,
    parameter int                 DWIDTH    = 32,
    parameter int                 DEPTH     = `MEM_DEPTH,
    parameter logic [AWIDTH-1:0]  BASE_ADDR = DEFAULT_BASE_ADDR,
    parameter int                 LATENCY   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [AWIDTH-1:0] req_addr_i,
    input  logic [DWIDTH-1:0] req_wdata_i,
    input  logic [2:0]        req_funct3_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DWIDTH-1:0] rsp_rdata_o,
    output logic              rsp_err_o
);

    localparam int WORDS = DEPTH / 4;
    localparam int WIW   = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int CW    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [AWIDTH:0] DEPTH_EXT = (AWIDTH + 1)'(DEPTH);

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                req_ready_q, req_ready_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DWIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                rsp_err_q, rsp_err_d;
    logic                we_q, we_d;
    logic [AWIDTH-1:0]   addr_q, addr_d;
    logic [DWIDTH-1:0]   wdata_q, wdata_d;
    logic [2:0]          funct3_q, funct3_d;

    logic [31:0]         mem_q [WORDS];

    logic [AWIDTH-1:0]   off_full;
    logic [AWIDTH:0]     off_ext;
    logic [AWIDTH:0]     size_m1;
    logic                out_range;
    logic [WIW-1:0]      word_idx;
    logic [31:0]         cur_word;
    logic [3:0]          lane_be;
    logic [31:0]         lane_merged;
    logic [31:0]         lane_load;
    logic                lane_misalign;
    logic                lane_illegal;
    logic                acc_err;
    logic                commit;
    logic                mem_we;

    assign req_ready_o = req_ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = rsp_err_q;

    // Range check on the latched address; the below-base test stops a wrapped offset
    always_comb begin
        off_full = addr_q - BASE_ADDR;
        off_ext  = {1'b0, off_full};
        case (funct3_q[1:0])
            2'd1:    size_m1 = (AWIDTH + 1)'(1);
            2'd2:    size_m1 = (AWIDTH + 1)'(3);
            default: size_m1 = '0;
        endcase
        out_range = (addr_q < BASE_ADDR) || (off_ext >= DEPTH_EXT)
                    || ((off_ext + size_m1) >= DEPTH_EXT);
        word_idx  = off_full[WIW+1:2];
    end

    assign cur_word = mem_q[word_idx];

    mem_lane_unit u_lane (
        .offset_i   (off_full[1:0]),
        .funct3_i   (funct3_q),
        .we_i       (we_q),
        .word_i     (cur_word),
        .wdata_i    (wdata_q[31:0]),
        .be_o       (lane_be),
        .merged_o   (lane_merged),
        .load_o     (lane_load),
        .misalign_o (lane_misalign),
        .illegal_o  (lane_illegal)
    );

    assign acc_err = out_range || lane_misalign || lane_illegal;
    assign commit  = (state_q == BUSY) && (cnt_q == '0);
    assign mem_we  = commit && we_q && !acc_err && (lane_be != 4'b0000);

    // Next-state and registered-output computation for the request/response FSM
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        funct3_d    = funct3_q;
        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    we_d        = req_we_i;
                    addr_d      = req_addr_i;
                    wdata_d     = req_wdata_i;
                    funct3_d    = req_funct3_i;
                    cnt_d       = CW'(LATENCY - 1);
                    req_ready_d = 1'b0;
                    state_d     = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = acc_err;
                    rsp_rdata_d = (acc_err || we_q) ? '0 : DWIDTH'(lane_load);
                    state_d     = RESP;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b0;
                    req_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                rsp_valid_d = 1'b0;
                req_ready_d = 1'b1;
                state_d     = IDLE;
            end
        endcase
    end

    // FSM state, counter, latched request and response registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            funct3_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            funct3_q    <= funct3_d;
        end
    end

    // Array write at the commit edge; contents survive reset
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[word_idx] <= lane_merged;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: expected responses are queued as each
// request is driven and compared when the responder hands the response over.
module tb_dmem_responder;

    localparam int          LAT  = 2;
    localparam int          DEP  = 64;
    localparam logic [31:0] BASE = 32'h1000_0000;

    typedef struct {
        string       tag;
        logic        err;
        logic [31:0] rdata;
    } expect_t;

    logic        clk;
    logic        rst;
    logic        reqValid;
    logic        reqReady;
    logic        reqWe;
    logic [31:0] reqAddr;
    logic [31:0] reqWdata;
    logic [2:0]  reqFunct3;
    logic        rspValid;
    logic        rspReady;
    logic [31:0] rspRdata;
    logic        rspErr;

    expect_t sbQ[$];
    int      testsRun = 0;
    int      failCount = 0;

    dmem_responder #(
        .AWIDTH    (32),
        .DWIDTH    (32),
        .DEPTH     (DEP),
        .BASE_ADDR (BASE),
        .LATENCY   (LAT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid_i  (reqValid),
        .req_ready_o  (reqReady),
        .req_we_i     (reqWe),
        .req_addr_i   (reqAddr),
        .req_wdata_i  (reqWdata),
        .req_funct3_i (reqFunct3),
        .rsp_valid_o  (rspValid),
        .rsp_ready_i  (rspReady),
        .rsp_rdata_o  (rspRdata),
        .rsp_err_o    (rspErr)
    );

    // Free-running clock, 10 time units per period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Scoreboard consumer: compare each response in the cycle it is handed over
    always @(negedge clk) begin
        if (!rst && rspValid && rspReady) begin
            if (sbQ.size() == 0) begin
                checkOutput("sbUnderflow", 32'd1, 32'd0);
            end else begin
                expect_t e;
                e = sbQ.pop_front();
                checkOutput({e.tag, ".err"}, {31'd0, rspErr}, {31'd0, e.err});
                checkOutput({e.tag, ".rdata"}, rspRdata, e.rdata);
            end
        end
    end

    // Drive one request, check its latency and handshake; optionally stall the response
    task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [2:0] f3, input logic expErr, input logic [31:0] expData,
                                 input string tag, input int hold);
        int guard;
        int lat;
        expect_t e;
        e.tag   = tag;
        e.err   = expErr;
        e.rdata = expData;
        guard = 0;
        @(negedge clk);
        while (!reqReady && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) begin
            checkOutput({tag, ".acceptTimeout"}, 32'd1, 32'd0);
            return;
        end
        sbQ.push_back(e);
        rspReady  = (hold == 0);
        reqValid  = 1'b1;
        reqWe     = we;
        reqAddr   = addr;
        reqWdata  = wdata;
        reqFunct3 = f3;
        @(posedge clk);
        #1;
        reqValid  = 1'b0;
        reqAddr   = $urandom;
        reqWdata  = $urandom;
        lat = 0;
        while (!rspValid && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput({tag, ".latency"}, 32'(lat), 32'(LAT));
        if (hold > 0) begin
            for (int i = 0; i < hold; i++) begin
                reqValid  = ~reqValid;
                reqWe     = 1'b1;
                reqAddr   = BASE;
                reqWdata  = 32'hBAD0_BAD0;
                reqFunct3 = 3'd2;
                @(posedge clk);
                #1;
                checkOutput({tag, ".holdValid"}, {31'd0, rspValid}, 32'd1);
                checkOutput({tag, ".holdData"}, rspRdata, expData);
                checkOutput({tag, ".holdReqReady"}, {31'd0, reqReady}, 32'd0);
            end
            reqValid = 1'b0;
            rspReady = 1'b1;
        end
        @(posedge clk);
        #1;
        checkOutput({tag, ".validPulse"}, {31'd0, rspValid}, 32'd0);
        checkOutput({tag, ".readyAfter"}, {31'd0, reqReady}, 32'd1);
    endtask

    // Overall watchdog so the run always terminates
    initial begin
        #200000;
        $display("[TB] FAIL watchdog got=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Test sequence
    initial begin
        rst       = 1'b1;
        reqValid  = 1'b0;
        reqWe     = 1'b0;
        reqAddr   = '0;
        reqWdata  = '0;
        reqFunct3 = '0;
        rspReady  = 1'b1;
        #1;
        checkOutput("reset.reqReady", {31'd0, reqReady}, 32'd1);
        checkOutput("reset.rspValid", {31'd0, rspValid}, 32'd0);
        checkOutput("reset.rdata", rspRdata, 32'd0);
        checkOutput("reset.err", {31'd0, rspErr}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        applyStimulus(1'b1, BASE,     32'hDEAD_BEEF, 3'd2, 1'b0, 32'h0,         "sw0",     0);
        applyStimulus(1'b0, BASE,     32'h0,         3'd2, 1'b0, 32'hDEAD_BEEF, "lw0",     0);
        applyStimulus(1'b1, BASE + 1, 32'h0000_0012, 3'd0, 1'b0, 32'h0,         "sb1",     0);
        applyStimulus(1'b0, BASE + 1, 32'h0,         3'd0, 1'b0, 32'h0000_0012, "lb1",     0);
        applyStimulus(1'b0, BASE,     32'h0,         3'd4, 1'b0, 32'h0000_00EF, "lbu0",    0);
        applyStimulus(1'b0, BASE,     32'h0,         3'd0, 1'b0, 32'hFFFF_FFEF, "lb0",     0);
        applyStimulus(1'b0, BASE + 2, 32'h0,         3'd1, 1'b0, 32'hFFFF_DEAD, "lh2",     0);
        applyStimulus(1'b0, BASE + 2, 32'h0,         3'd5, 1'b0, 32'h0000_DEAD, "lhu2",    0);
        applyStimulus(1'b0, BASE,     32'h0,         3'd1, 1'b0, 32'h0000_12EF, "lh0",     0);
        applyStimulus(1'b0, BASE,     32'h0,         3'd2, 1'b0, 32'hDEAD_12EF, "lwMerged",0);

        applyStimulus(1'b0, BASE + 2,       32'h0,         3'd2, 1'b1, 32'h0, "lwMis",     0);
        applyStimulus(1'b1, BASE + 1,       32'h0000_5555, 3'd1, 1'b1, 32'h0, "shMis",     0);
        applyStimulus(1'b0, 32'h00FF_FFFC,  32'h0,         3'd2, 1'b1, 32'h0, "lwBelow",   0);
        applyStimulus(1'b0, BASE + DEP - 2, 32'h0,         3'd2, 1'b1, 32'h0, "lwEnd",     0);
        applyStimulus(1'b0, BASE + DEP,     32'h0,         3'd2, 1'b1, 32'h0, "lwPastEnd", 0);
        applyStimulus(1'b1, BASE + DEP - 4, 32'hA5A5_5A5A, 3'd2, 1'b0, 32'h0, "swLast",    0);
        applyStimulus(1'b0, BASE + DEP - 4, 32'h0,         3'd2, 1'b0, 32'hA5A5_5A5A, "lwLast", 0);
        applyStimulus(1'b0, BASE,           32'h0,         3'd2, 1'b0, 32'hDEAD_12EF, "lwAfterErr", 0);

        applyStimulus(1'b0, BASE, 32'h0,         3'd3, 1'b1, 32'h0, "ldF3", 0);
        applyStimulus(1'b1, BASE, 32'h0000_0000, 3'd4, 1'b1, 32'h0, "stF3", 0);
        applyStimulus(1'b0, BASE, 32'h0,         3'd2, 1'b0, 32'hDEAD_12EF, "lwAfterF3", 0);

        applyStimulus(1'b0, BASE, 32'h0, 3'd2, 1'b0, 32'hDEAD_12EF, "lwHold", 5);
        applyStimulus(1'b0, BASE, 32'h0, 3'd2, 1'b0, 32'hDEAD_12EF, "lwAfterHold", 0);

        applyStimulus(1'b1, BASE + 32'h10, 32'h0102_0304, 3'd2, 1'b0, 32'h0, "swPrior", 0);
        @(negedge clk);
        reqValid  = 1'b1;
        reqWe     = 1'b1;
        reqAddr   = BASE + 32'h10;
        reqWdata  = 32'hCAFE_F00D;
        reqFunct3 = 3'd2;
        @(posedge clk);
        #1;
        reqValid = 1'b0;
        checkOutput("busy.reqReady", {31'd0, reqReady}, 32'd0);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midReset.reqReady", {31'd0, reqReady}, 32'd1);
        checkOutput("midReset.rspValid", {31'd0, rspValid}, 32'd0);
        checkOutput("midReset.rdata", rspRdata, 32'd0);
        checkOutput("midReset.err", {31'd0, rspErr}, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        applyStimulus(1'b0, BASE + 32'h10, 32'h0, 3'd2, 1'b0, 32'h0102_0304, "lwAfterReset", 0);

        repeat (2) @(negedge clk);
        checkOutput("sbEmpty", 32'(sbQ.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
